// File: rtl/btn_pkg.sv
// Shared types and helpers for the multi-channel button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } btn_state_t;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 32'd1);
    return (w == 0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: 2-flop synchroniser, edge debounce FSM, long-press and auto-repeat timing.
module btn_debounce_chan
  import btn_pkg::*;
#(
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int unsigned DEB_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = cnt_width(LONG_CYCLES);
  localparam int unsigned REP_W  = cnt_width(REPEAT_CYCLES);

  localparam logic              IDLE_LVL  = (ACTIVE_LOW != 0);
  localparam logic              REP_EN    = (REPEAT_CYCLES != 0);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 32'd1);
  localparam logic [REP_W-1:0]  REP_LAST  =
    REP_W'((REPEAT_CYCLES == 0) ? 32'd0 : REPEAT_CYCLES - 32'd1);

  btn_state_t        state_q, state_d;
  logic              s1_q, s1_d, s2_q, s2_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic              long_done_q, long_done_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              repeat_q, repeat_d;
  logic              act_c;

  // Synchroniser resets to the idle pad level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s1_q        <= IDLE_LVL;
      s2_q        <= IDLE_LVL;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      rep_cnt_q   <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  assign act_c = s2_q ^ IDLE_LVL;

  always_comb begin
    s1_d        = btn_raw;
    s2_d        = s1_q;
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (act_c) begin
          state_d   = PRESS_CHK;
          deb_cnt_d = '0;
        end
      end
      PRESS_CHK: begin
        if (!act_c) begin
          state_d = IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d     = HELD;
          press_d     = 1'b1;
          level_d     = 1'b1;
          hold_cnt_d  = '0;
          long_done_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      HELD: begin
        if (!act_c) begin
          state_d   = REL_CHK;
          deb_cnt_d = '0;
        end else if (!long_done_q) begin
          if (hold_cnt_q == HOLD_LAST) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
            rep_cnt_d   = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end else if (REP_EN) begin
          if (rep_cnt_q == REP_LAST) begin
            repeat_d  = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
        end
      end
      REL_CHK: begin
        // Hold/repeat counters stay frozen so a release bounce resumes timing.
        if (act_c) begin
          state_d = HELD;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/btn_debounce_multi.sv
// N independent debounced button channels with press/release/long/repeat event pulses.
module btn_debounce_multi #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse
);

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_chan
    btn_debounce_chan #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .btn_raw       (btn_raw[i]),
      .btn_level     (btn_level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Self-checking bench for btn_debounce_multi: vector table, timed corner sequences, random vs. model.
module tb_btn_debounce_multi;

  localparam int D = 4;
  localparam int L = 10;
  localparam int R = 3;

  logic       clk;
  logic       rst;
  logic [1:0] btn_raw;
  logic [1:0] btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;

  btn_debounce_multi #(
    .N_BTN(2), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: act is raw delayed two samples; an edge is accepted after D+1
  // consecutive agreeing samples; held time counts held samples that follow a held sample.
  bit         m_d1[2], m_d2[2], m_lvl[2], m_pa[2];
  int         m_run[2], m_h[2];
  logic [1:0] e_lvl, e_pr, e_rl, e_lg, e_rp;

  task automatic model_step(input logic [1:0] raw_v, input logic rst_v);
    bit a;
    e_pr = '0; e_rl = '0; e_lg = '0; e_rp = '0;
    for (int c = 0; c < 2; c++) begin
      if (rst_v) begin
        m_d1[c] = 0; m_d2[c] = 0; m_lvl[c] = 0; m_pa[c] = 0; m_run[c] = 0; m_h[c] = 0;
      end else begin
        a = m_d2[c];
        m_d2[c] = m_d1[c];
        m_d1[c] = (raw_v[c] == 1'b0);
        if (!m_lvl[c]) begin
          m_run[c] = a ? m_run[c] + 1 : 0;
          if (m_run[c] == D + 1) begin
            m_lvl[c] = 1; e_pr[c] = 1'b1; m_run[c] = 0; m_h[c] = 0;
          end
        end else begin
          if (a && m_pa[c]) begin
            m_h[c]++;
            if (m_h[c] == L) e_lg[c] = 1'b1;
            else if (m_h[c] > L && R != 0 && (m_h[c] - L) % R == 0) e_rp[c] = 1'b1;
          end
          m_run[c] = !a ? m_run[c] + 1 : 0;
          if (m_run[c] == D + 1) begin
            m_lvl[c] = 0; e_rl[c] = 1'b1; m_run[c] = 0;
          end
        end
        m_pa[c] = a;
      end
      e_lvl[c] = m_lvl[c];
    end
  endtask

  // Per-segment event trackers (tick index relative to the last trk_reset).
  int seg_t, both_t;
  int press_t[2], rel_t[2], long_t[2], rep_first[2], rep_last[2];
  int n_press[2], n_rel[2], n_long[2], n_rep[2];

  task automatic trk_reset();
    seg_t = 0; both_t = -1;
    for (int c = 0; c < 2; c++) begin
      press_t[c] = -1; rel_t[c] = -1; long_t[c] = -1; rep_first[c] = -1; rep_last[c] = -1;
      n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0; n_rep[c] = 0;
    end
  endtask

  task automatic tick(input logic [1:0] raw_v, input logic rst_v);
    btn_raw = raw_v;
    rst     = rst_v;
    @(posedge clk);
    model_step(raw_v, rst_v);
    #1;
    check("model", {22'd0, btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse},
          {22'd0, e_lvl, e_pr, e_rl, e_lg, e_rp});
    for (int c = 0; c < 2; c++) begin
      if (press_pulse[c])   begin n_press[c]++; if (press_t[c] < 0) press_t[c] = seg_t; end
      if (release_pulse[c]) begin n_rel[c]++;   if (rel_t[c] < 0)   rel_t[c]   = seg_t; end
      if (long_pulse[c])    begin n_long[c]++;  if (long_t[c] < 0)  long_t[c]  = seg_t; end
      if (repeat_pulse[c]) begin
        n_rep[c]++;
        if (rep_first[c] < 0) rep_first[c] = seg_t;
        rep_last[c] = seg_t;
      end
    end
    if (press_pulse == 2'b11 && both_t < 0) both_t = seg_t;
    seg_t++;
  endtask

  task automatic seg(input logic [1:0] raw_v, input int n);
    for (int i = 0; i < n; i++) tick(raw_v, 1'b0);
  endtask

  typedef struct {
    logic [1:0] raw;
    logic [1:0] lvl;
    logic [1:0] pr;
    logic [1:0] rl;
  } vec_t;

  vec_t tv[24];
  logic [1:0] rnd_raw;

  initial begin
    // Clean press (edges 0..7), clean release (8..15), 3-cycle glitch (16..23).
    for (int i = 0; i < 24; i++) begin
      tv[i].raw = (i < 8 || (i >= 16 && i < 19)) ? 2'b10 : 2'b11;
      tv[i].lvl = (i >= 6 && i < 14) ? 2'b01 : 2'b00;
      tv[i].pr  = (i == 6) ? 2'b01 : 2'b00;
      tv[i].rl  = (i == 14) ? 2'b01 : 2'b00;
    end

    btn_raw = 2'b11;
    rst     = 1'b1;
    trk_reset();
    model_step(2'b11, 1'b1);
    tick(2'b11, 1'b1);
    tick(2'b11, 1'b1);
    check("reset_state", {22'd0, btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse}, 32'd0);

    for (int i = 0; i < 24; i++) begin
      tick(tv[i].raw, 1'b0);
      check($sformatf("vec%0d", i), {24'd0, btn_level, press_pulse, release_pulse, long_pulse},
            {24'd0, tv[i].lvl, tv[i].pr, tv[i].rl, 2'b00});
    end

    // Long press then auto-repeat while held.
    trk_reset();
    seg(2'b10, 37);
    check("lp_press_t", press_t[0], 6);
    check("lp_long_t", long_t[0], 16);
    check("lp_long_n", n_long[0], 1);
    check("lp_rep_first", rep_first[0], 19);
    check("lp_rep_last", rep_last[0], 34);
    check("lp_rep_n", n_rep[0], 6);

    // Release bounce is ignored, then a clean release is accepted once.
    trk_reset();
    seg(2'b11, 2);
    seg(2'b10, 6);
    check("bounce_rel_n", n_rel[0], 0);
    check("bounce_level", btn_level[0], 1);
    trk_reset();
    seg(2'b11, 8);
    check("rel_t", rel_t[0], 6);
    check("rel_n", n_rel[0], 1);
    check("rel_level", btn_level[0], 0);
    seg(2'b11, 2);

    // Reset while held: outputs clear without release, held button re-pressed.
    trk_reset();
    seg(2'b10, 10);
    check("pre_rst_level", btn_level[0], 1);
    tick(2'b10, 1'b1);
    check("rst_clear", {22'd0, btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse}, 32'd0);
    trk_reset();
    seg(2'b10, 10);
    check("rst_repress_t", press_t[0], 6);
    check("rst_no_rel", n_rel[0], 0);
    seg(2'b11, 10);

    // Both channels pressed together; ch1 released while ch0 keeps timing.
    trk_reset();
    seg(2'b00, 8);
    seg(2'b10, 29);
    check("dual_press_t", both_t, 6);
    check("dual_ch1_rel_t", rel_t[1], 14);
    check("dual_ch1_long_n", n_long[1], 0);
    check("dual_ch0_long_t", long_t[0], 16);
    check("dual_ch0_rep_first", rep_first[0], 19);
    check("dual_ch0_rep_n", n_rep[0], 6);
    seg(2'b11, 10);

    // Random bouncing pads with occasional reset, checked cycle-by-cycle.
    rnd_raw = 2'b11;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 2; c++)
        if ($urandom_range(0, 99) < 5) rnd_raw[c] = ~rnd_raw[c];
      tick(rnd_raw, ($urandom_range(0, 599) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
